cos_result_buffer: RTL and testbench

//  Downstream stage of the cosine unit. Captures each {intpart,fracpart} result on a done rising edge.

---
 rtl/cos_result_buffer.sv | 115 +++++++++++
 tb/tb_cos_result_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cos_result_buffer.sv
// Result FIFO behind the cosine unit: captures on done rising edges, tags results with a sequence number, and drains them through a valid/ready port.
// Optional build macro COS_RESULT_CLAMP_EN clamps stored results above 1.0 to exactly 1.0.
module cos_result_buffer #(
   parameter int DEPTH = 4,
   parameter int SEQ_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       done,
   input  logic [1:0]                 intpart,
   input  logic [7:0]                 fracpart,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [9:0]                 out_data,
   output logic [SEQ_W-1:0]           out_seq,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       clamp_seen
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [9:0]       memData [DEPTH];
   logic [SEQ_W-1:0] memSeq  [DEPTH];

   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic             done_q;
   logic             overflow_q, overflow_d;
   logic             clampSeen_q, clampSeen_d;

   logic             cap, pop, full, push, needClamp;
   logic [9:0]       wrData;

   assign cap  = done && !done_q;
   assign pop  = out_valid && out_ready;
   assign full = (count_q == CW'(DEPTH));
   // A full FIFO can still accept a result when the head leaves on the same edge.
   assign push = cap && (!full || pop);

`ifdef COS_RESULT_CLAMP_EN
   assign needClamp = (intpart >= 2'd2) || ((intpart == 2'd1) && (fracpart != 8'd0));
   assign wrData    = needClamp ? 10'b01_0000_0000 : {intpart, fracpart};
`else
   assign needClamp = 1'b0;
   assign wrData    = {intpart, fracpart};
`endif

   always_comb begin
      wrPtr_d     = wrPtr_q;
      rdPtr_d     = rdPtr_q;
      count_d     = count_q;
      seq_d       = seq_q;
      overflow_d  = overflow_q;
      clampSeen_d = clampSeen_q;
      if (clear) begin
         wrPtr_d     = '0;
         rdPtr_d     = '0;
         count_d     = '0;
         seq_d       = '0;
         overflow_d  = 1'b0;
         clampSeen_d = 1'b0;
      end else begin
         if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
            if (needClamp) clampSeen_d = 1'b1;
         end
         if (pop) rdPtr_d = rdPtr_q + 1'b1;
         if (push && !pop) count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
         // The tag advances even for dropped results so the consumer sees the gap.
         if (cap) seq_d = seq_q + 1'b1;
         if (cap && !push) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         seq_q       <= '0;
         done_q      <= 1'b1;
         overflow_q  <= 1'b0;
         clampSeen_q <= 1'b0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         seq_q       <= seq_d;
         done_q      <= done;
         overflow_q  <= overflow_d;
         clampSeen_q <= clampSeen_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         memData[wrPtr_q] <= wrData;
         memSeq[wrPtr_q]  <= seq_q;
      end
   end

   assign out_valid  = (count_q != '0);
   assign out_data   = memData[rdPtr_q];
   assign out_seq    = memSeq[rdPtr_q];
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign clamp_seen = clampSeen_q;

endmodule

// File: tb/tb_cos_result_buffer.sv
// Bench for cos_result_buffer: queue-based reference model checked every cycle plus directed literal checks.
// Honours COS_RESULT_CLAMP_EN the same way as the design.
module tb_cos_result_buffer;

   localparam int DEPTH = 4;
   localparam int SEQ_W = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       done = 1'b1;
   logic [1:0] intpart = 2'd0;
   logic [7:0] fracpart = 8'd0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [9:0] out_data;
   logic [SEQ_W-1:0] out_seq;
   logic [2:0] count;
   logic       overflow;
   logic       clamp_seen;

   int vectors = 0;
   int miscompares = 0;

   cos_result_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .clk(clk), .rst(rst), .clear(clear), .done(done),
      .intpart(intpart), .fracpart(fracpart),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_seq(out_seq),
      .count(count), .overflow(overflow), .clamp_seen(clamp_seen)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of (value, tag) pairs plus sticky flags.
   int  mData[$];
   int  mSeq[$];
   int  mNextSeq;
   bit  mOverflow, mClamp, mDonePrev, mCap, mPop;
   int  mValue;

   function automatic int storedValue(input int v);
`ifdef COS_RESULT_CLAMP_EN
      return (v > 256) ? 256 : v;
`else
      return v;
`endif
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mData.delete(); mSeq.delete();
         mNextSeq = 0; mOverflow = 0; mClamp = 0; mDonePrev = 1;
      end else begin
         mCap = done && !mDonePrev;
         mPop = (mData.size() != 0) && out_ready;
         mDonePrev = done;
         if (clear) begin
            mData.delete(); mSeq.delete();
            mNextSeq = 0; mOverflow = 0; mClamp = 0;
         end else begin
            if (mPop) begin
               void'(mData.pop_front());
               void'(mSeq.pop_front());
            end
            if (mCap) begin
               if (mData.size() < DEPTH) begin
                  mValue = int'({intpart, fracpart});
                  if (storedValue(mValue) != mValue) mClamp = 1;
                  mData.push_back(storedValue(mValue));
                  mSeq.push_back(mNextSeq);
               end else begin
                  mOverflow = 1;
               end
               mNextSeq = (mNextSeq + 1) % (1 << SEQ_W);
            end
         end
      end
   end

   task automatic cmp(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         cmp("model.out_valid", int'(out_valid), int'(mData.size() != 0));
         cmp("model.count", int'(count), mData.size());
         cmp("model.overflow", int'(overflow), int'(mOverflow));
         cmp("model.clamp_seen", int'(clamp_seen), int'(mClamp));
         if (mData.size() != 0) begin
            cmp("model.out_data", int'(out_data), mData[0]);
            cmp("model.out_seq", int'(out_seq), mSeq[0]);
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      cmp(name, actual, expected);
   endtask

   task automatic cycle(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   // One capture: raise done with the value for one edge, then lower it.
   task automatic applyStimulus(input logic [9:0] v);
      {intpart, fracpart} = v;
      done = 1'b1;
      cycle();
      done = 1'b0;
      cycle();
   endtask

   task automatic doClear();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   initial begin
      // 1: reset with done held high; release must not capture
      #1 rst = 1'b0;
      cycle(2);
      rst = 1'b1;
      cycle(2);
      checkOutput("t1.count", int'(count), 0);
      checkOutput("t1.out_valid", int'(out_valid), 0);

      // 2: single capture, visible right after the capture edge
      done = 1'b0;
      cycle();
      {intpart, fracpart} = 10'h180;
      done = 1'b1;
      cycle();
      checkOutput("t2.out_valid", int'(out_valid), 1);
`ifdef COS_RESULT_CLAMP_EN
      checkOutput("t2.out_data", int'(out_data), 'h100);
`else
      checkOutput("t2.out_data", int'(out_data), 'h180);
`endif
      checkOutput("t2.out_seq", int'(out_seq), 0);
      checkOutput("t2.count", int'(count), 1);
      done = 1'b0;
      cycle();

      // 3: overflow on the fifth capture, tag gap afterwards
      doClear();
      for (int i = 0; i < 5; i++) applyStimulus(10'h040 + 10'(i));
      checkOutput("t3.count", int'(count), 4);
      checkOutput("t3.overflow", int'(overflow), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("t3.drain_seq", int'(out_seq), i);
         checkOutput("t3.drain_data", int'(out_data), 'h040 + i);
         cycle();
      end
      out_ready = 1'b0;
      checkOutput("t3.empty", int'(out_valid), 0);
      applyStimulus(10'h045);
      checkOutput("t3.gap_seq", int'(out_seq), 5);
      checkOutput("t3.gap_count", int'(count), 1);

      // 4: full FIFO with push and pop on the same edge
      doClear();
      for (int i = 0; i < 4; i++) applyStimulus(10'h050 + 10'(i));
      {intpart, fracpart} = 10'h054;
      done = 1'b1;
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      done = 1'b0;
      checkOutput("t4.count", int'(count), 4);
      checkOutput("t4.overflow", int'(overflow), 0);
      checkOutput("t4.head_data", int'(out_data), 'h051);
      checkOutput("t4.head_seq", int'(out_seq), 1);
      cycle();
      out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         checkOutput("t4.drain_data", int'(out_data), 'h050 + i);
         checkOutput("t4.drain_seq", int'(out_seq), i);
         cycle();
      end
      out_ready = 1'b0;

      // 5: value above 1.0
      doClear();
      applyStimulus(10'h201);
`ifdef COS_RESULT_CLAMP_EN
      checkOutput("t5.out_data", int'(out_data), 'h100);
      checkOutput("t5.clamp_seen", int'(clamp_seen), 1);
`else
      checkOutput("t5.out_data", int'(out_data), 'h201);
      checkOutput("t5.clamp_seen", int'(clamp_seen), 0);
`endif

      // 6: clear beats a simultaneous capture, then async reset mid-drain
      doClear();
      for (int i = 0; i < 5; i++) applyStimulus(10'h060 + 10'(i));
      checkOutput("t6.pre_overflow", int'(overflow), 1);
      {intpart, fracpart} = 10'h0AA;
      done = 1'b1;
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      done = 1'b0;
      checkOutput("t6.count", int'(count), 0);
      checkOutput("t6.out_valid", int'(out_valid), 0);
      checkOutput("t6.overflow", int'(overflow), 0);
      cycle();
      for (int i = 0; i < 3; i++) applyStimulus(10'h070 + 10'(i));
      checkOutput("t6.seq_restart", int'(out_seq), 0);
      out_ready = 1'b1;
      cycle();
      checkOutput("t6.drain_valid", int'(out_valid), 1);
      rst = 1'b0;
      #1;
      checkOutput("t6.async_valid", int'(out_valid), 0);
      checkOutput("t6.async_count", int'(count), 0);
      out_ready = 1'b0;
      cycle();
      rst = 1'b1;
      cycle(2);
      checkOutput("t6.post_reset_valid", int'(out_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
